// File: rtl/borrow_cla_sub.sv
// borrow_cla_sub
// Two-stage pipelined subtractor computing diff = a - b - bin (mod 2^WIDTH)
// with borrow-lookahead inside each half-width slice.
//   Stage 1: low half difference and low-half borrow-out, high operand halves.
//   Stage 2: high half from the registered low-half borrow, plus flags.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand bundle valid        in_ready   bundle can be accepted
//   a, b, bin  minuend, subtrahend, borrow-in
//   out_valid  result valid                out_ready  consumer accepts result
//   diff       a - b - bin                 bout       unsigned borrow-out
//   zero       diff == 0                   neg        diff MSB
//   ovf        signed overflow
//
// Handshake: a bundle moves across an interface on a rising edge where its
// valid and ready are both high. A producer holding valid keeps its data
// stable until the transfer; out_valid and the result hold while out_ready
// is low.

module borrow_cla_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int H = WIDTH / 2;

    // Flattened borrow lookahead: borrow out of bit i is the OR of
    //   g[j] & p[j+1] & ... & p[i]   for every j <= i, and
    //   cin  & p[0]   & ... & p[i].
    // Every borrow is a two-level sum of products, never a chain through
    // the previous bit's borrow.
    function automatic logic [H-1:0] lookahead(input logic [H-1:0] g,
                                               input logic [H-1:0] p,
                                               input logic         cin);
        logic [H-1:0] brw;
        logic         term;
        brw = '0;
        for (int i = 0; i < H; i++) begin
            term = cin;
            for (int k = 0; k <= i; k++) term = term & p[k];
            brw[i] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                brw[i] = brw[i] | term;
            end
        end
        return brw;
    endfunction

    // ---------------- stage 1 combinational ----------------
    logic [H-1:0] lo_g, lo_p, lo_brw, lo_diff;

    always_comb begin
        lo_g    = ~a[H-1:0] & b[H-1:0];
        lo_p    = ~(a[H-1:0] ^ b[H-1:0]);
        lo_brw  = lookahead(lo_g, lo_p, bin);
        lo_diff = a[H-1:0] ^ b[H-1:0] ^ {lo_brw[H-2:0], bin};
    end

    // ---------------- pipeline control ----------------
    logic         live;        // low during reset, high from the first edge after release
    logic         s1_valid;
    logic [H-1:0] s1_diff_lo;
    logic         s1_bout_lo;
    logic [H-1:0] s1_a_hi;     // a_hi[H-1] is a's MSB, reused for overflow
    logic [H-1:0] s1_b_hi;
    logic         s1_adv;
    logic         accept;

    assign s1_adv   = ~out_valid | out_ready;
    assign in_ready = live & (~s1_valid | s1_adv);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_diff_lo <= '0;
            s1_bout_lo <= 1'b0;
            s1_a_hi    <= '0;
            s1_b_hi    <= '0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_diff_lo <= lo_diff;
            s1_bout_lo <= lo_brw[H-1];
            s1_a_hi    <= a[WIDTH-1:H];
            s1_b_hi    <= b[WIDTH-1:H];
        end else if (s1_adv) begin
            // Stage 1 drained into stage 2 and nothing replaced it.
            s1_valid <= 1'b0;
        end
    end

    // ---------------- stage 2 combinational ----------------
    logic [H-1:0]     hi_g, hi_p, hi_brw, hi_diff;
    logic [WIDTH-1:0] full_diff;

    always_comb begin
        hi_g      = ~s1_a_hi & s1_b_hi;
        hi_p      = ~(s1_a_hi ^ s1_b_hi);
        hi_brw    = lookahead(hi_g, hi_p, s1_bout_lo);
        hi_diff   = s1_a_hi ^ s1_b_hi ^ {hi_brw[H-2:0], s1_bout_lo};
        full_diff = {hi_diff, s1_diff_lo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                diff <= full_diff;
                bout <= hi_brw[H-1];
                zero <= (full_diff == '0);
                neg  <= full_diff[WIDTH-1];
                ovf  <= (s1_a_hi[H-1] ^ s1_b_hi[H-1]) &
                        (full_diff[WIDTH-1] ^ s1_a_hi[H-1]);
            end
        end
    end

endmodule

// File: tb/tb_borrow_cla_sub.sv
module tb_borrow_cla_sub;

    localparam int W = 16;
    localparam int RW = W + 4;  // packed result {diff, bout, zero, neg, ovf}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          bin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  diff;
    logic          bout, zero, neg, ovf;

    int checks = 0;
    int failures = 0;
    int stalls = 0;
    int n_results = 0;
    bit rand_on = 1'b0;

    logic [RW-1:0] exp_q[$];

    borrow_cla_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .zero(zero), .neg(neg), .ovf(ovf)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] model(input logic [W-1:0] ma,
                                            input logic [W-1:0] mb,
                                            input logic mbin);
        logic [W:0]   full;
        logic [W-1:0] d;
        full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        d = full[W-1:0];
        return {d, full[W], (d == '0), d[W-1],
                (ma[W-1] ^ mb[W-1]) & (d[W-1] ^ ma[W-1])};
    endfunction

    // ---------------- driver tasks ----------------
    // Drives a bundle from a falling edge and holds it until accepted.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vbin, input logic [RW-1:0] vexp);
        int waits;
        waits = 0;
        @(negedge clk);
        in_valid = 1'b1; a = va; b = vb; bin = vbin;
        forever begin
            #4;
            if (in_ready) begin
                exp_q.push_back(vexp);
                break;
            end
            stalls++;
            waits++;
            if (waits > 200) begin
                check_eq("send_timeout", 32'(waits), 32'd0);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard ----------------
    initial begin
        logic [RW-1:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    n_results++;
                    check_eq("result", 32'({diff, bout, zero, neg, ovf}), 32'(e));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_on) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic [W-1:0]  va;
        logic [W-1:0]  vb;
        logic          vbin;
        logic [RW-1:0] vexp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, {16'h1000, 4'b0000}};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, {16'hFFFF, 4'b1010}};
        vecs[2] = '{16'h0100, 16'h00FF, 1'b1, {16'h0000, 4'b0100}};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, {16'h7FFF, 4'b0001}};
        vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 4'b1011}};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, {16'hFFFF, 4'b1010}};
        vecs[6] = '{16'h00FF, 16'h00FF, 1'b0, {16'h0000, 4'b0100}};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, {16'hFFFF, 4'b1010}};
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] ra, rb;
        logic         rbin;

        // Reset state
        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_outputs", 32'({diff, bout, zero, neg, ovf}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        #4;
        check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Latency of a single bundle
        send(vecs[0].va, vecs[0].vb, vecs[0].vbin, vecs[0].vexp);
        idle(1);
        #4;
        check_eq("lat_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        #4;
        check_eq("lat_cycle2", 32'(out_valid), 32'd1);
        drain();

        // Back-to-back directed vectors, no stalls expected
        stalls = 0;
        for (int i = 1; i < 8; i++) send(vecs[i].va, vecs[i].vb, vecs[i].vbin, vecs[i].vexp);
        idle(1);
        check_eq("no_stalls", 32'(stalls), 32'd0);
        drain();

        // Backpressure: three bundles with out_ready low
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; a = vecs[3].va; b = vecs[3].vb; bin = vecs[3].vbin;
        #4;
        check_eq("bp_acc1", 32'(in_ready), 32'd1);
        exp_q.push_back(vecs[3].vexp);
        @(negedge clk);
        a = vecs[4].va; b = vecs[4].vb; bin = vecs[4].vbin;
        #4;
        check_eq("bp_acc2", 32'(in_ready), 32'd1);
        exp_q.push_back(vecs[4].vexp);
        @(negedge clk);
        a = vecs[2].va; b = vecs[2].vb; bin = vecs[2].vbin;
        #4;
        check_eq("bp_full", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        #4;
        check_eq("bp_still_full", 32'(in_ready), 32'd0);
        check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
        check_eq("bp_hold_data", 32'({diff, bout, zero, neg, ovf}), 32'(vecs[3].vexp));
        @(negedge clk);
        out_ready = 1'b1;
        #4;
        check_eq("bp_pop_push", 32'(in_ready), 32'd1);
        exp_q.push_back(vecs[2].vexp);
        n_results = 0;
        idle(1);
        drain();
        check_eq("bp_count", 32'(n_results), 32'd3);

        // Reset while both stages hold data
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; a = vecs[1].va; b = vecs[1].vb; bin = vecs[1].vbin;
        @(negedge clk);
        a = vecs[4].va; b = vecs[4].vb; bin = vecs[4].vbin;
        @(negedge clk);
        in_valid = 1'b0;
        #4;
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_outputs", 32'({diff, bout, zero, neg, ovf}), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        n_results = 0;
        repeat (5) @(negedge clk);
        check_eq("no_stale", 32'(n_results), 32'd0);
        check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Random bundles with random valid gaps and out_ready
        rand_on = 1'b1;
        n_results = 0;
        for (int i = 0; i < 3000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rbin = 1'($urandom_range(0, 1));
            send(ra, rb, rbin, model(ra, rb, rbin));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(1);
        @(negedge clk);
        rand_on = 1'b0;
        out_ready = 1'b1;
        drain();
        check_eq("rand_count", 32'(n_results), 32'd3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
